// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO controller for an external 1-cycle-latency memory with a registered output word.
// Optional macro FIFO_CTRL_OVF_EN adds the sticky ovf_err output.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_ADDR   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(MAX_ADDR):0]   count,
    output logic                        mem_wr_en,
    output logic                        mem_rd_en,
    output logic [$clog2(MAX_ADDR)-1:0] mem_wr_addr,
    output logic [$clog2(MAX_ADDR)-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0]       mem_wr_data,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data
`ifdef FIFO_CTRL_OVF_EN
    ,
    output logic                        ovf_err
`endif
);
    localparam int AW = $clog2(MAX_ADDR);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  full, wr_fire, rd_fire;
`ifdef FIFO_CTRL_OVF_EN
    logic                  ovf_q, ovf_d;
`endif

    // Handshakes are suppressed during rst so reset wins over any strobe
    always_comb begin
        full        = count_q == CW'(MAX_ADDR);
        wr_fire     = in_valid && !full && !rst;
        rd_fire     = !rst && count_q != '0 && (state_q == IDLE || (state_q == HOLD && out_ready));
        state_d     = rd_fire ? READ : state_q == READ ? HOLD : (state_q == HOLD && out_ready) ? IDLE : state_q;
        out_valid_d = state_d == HOLD;
        out_data_d  = state_q == READ ? mem_rd_data : out_data_q;
        wr_ptr_d    = wr_ptr_q + AW'(wr_fire);
        rd_ptr_d    = rd_ptr_q + AW'(rd_fire);
        count_d     = count_q + CW'(wr_fire) - CW'(rd_fire);
`ifdef FIFO_CTRL_OVF_EN
        ovf_d       = ovf_q | (in_valid && full);
`endif
    end

    // Pointers, occupancy, read FSM and registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef FIFO_CTRL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef FIFO_CTRL_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready    = !full;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign count       = count_q;
    assign mem_wr_en   = wr_fire;
    assign mem_rd_en   = rd_fire;
    assign mem_wr_addr = wr_ptr_q;
    assign mem_rd_addr = rd_ptr_q;
    assign mem_wr_data = in_data;
`ifdef FIFO_CTRL_OVF_EN
    assign ovf_err     = ovf_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a behavioural 1-cycle-latency memory.
module tb_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data, mem_wr_data, mem_rd_data;
    logic [2:0] count;
    logic       mem_wr_en, mem_rd_en;
    logic [1:0] mem_wr_addr, mem_rd_addr;
`ifdef FIFO_CTRL_OVF_EN
    logic       ovf_err;
`endif
    logic [7:0] mem [4];
    logic [7:0] got [$];
    int         got_t [$];
    int         ncyc = 0, total = 0, passed = 0;

    fifo_ctrl #(.DATA_WIDTH(8), .MAX_ADDR(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef FIFO_CTRL_OVF_EN
        , .ovf_err(ovf_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic cyc();
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_t.push_back(ncyc);
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_a [5];
        exp_a = '{128, 56, 74, 200, 17};
        rst = 1'b1;
        drive(0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        drive(1, 128, 0);
        chk("w0_wr_en", mem_wr_en, 1);
        chk("w0_wr_addr", mem_wr_addr, 0);
        chk("w0_wr_data", mem_wr_data, 128);
        chk("empty_no_read", mem_rd_en, 0);
        cyc();
        drive(1, 56, 0);
        chk("w1_rd_en", mem_rd_en, 1);
        chk("w1_rd_addr", mem_rd_addr, 0);
        chk("w1_wr_addr", mem_wr_addr, 1);
        cyc();
        chk("w1_count", count, 1);
        drive(1, 74, 0);
        cyc();
        drive(1, 200, 0);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 128);
        cyc();
        drive(0, 0, 0);
        chk("four_count", count, 3);
        chk("four_valid", out_valid, 1);
        chk("four_data", out_data, 128);
        chk("four_in_ready", in_ready, 1);
        drive(1, 17, 0);
        cyc();
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        drive(1, 99, 0);
        chk("full_no_wr", mem_wr_en, 0);
        cyc();
        chk("full_count_kept", count, 4);
        chk("full_data_kept", out_data, 128);
`ifdef FIFO_CTRL_OVF_EN
        chk("ovf_set", ovf_err, 1);
`endif
        got.delete();
        got_t.delete();
        drive(0, 0, 1);
        for (int i = 0; i < 12; i++) cyc();
        chk("drain_n", got.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("drain_%0d", i), got[i], exp_a[i]);
        chk("drain_rate", got_t[4] - got_t[0], 8);
        chk("drain_count", count, 0);
        chk("drain_idle_valid", out_valid, 0);
        chk("drain_idle_rd", mem_rd_en, 0);
        got.delete();
        drive(1, 1, 1);
        cyc();
        drive(1, 2, 1);
        cyc();
        drive(1, 3, 1);
        cyc();
        drive(1, 4, 1);
        chk("wrap_wr_addr", mem_wr_addr, 0);
        chk("both_wr_en", mem_wr_en, 1);
        chk("both_rd_en", mem_rd_en, 1);
        chk("both_count_pre", count, 2);
        cyc();
        chk("both_count_post", count, 2);
        drive(1, 5, 1);
        cyc();
        drive(1, 6, 1);
        cyc();
        drive(0, 0, 1);
        for (int i = 0; i < 12; i++) cyc();
        chk("wrap_n", got.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("wrap_%0d", i), got[i], i + 1);
        chk("wrap_count", count, 0);
`ifdef FIFO_CTRL_OVF_EN
        chk("ovf_sticky", ovf_err, 1);
`endif
        drive(1, 7, 0);
        cyc();
        drive(0, 0, 0);
        chk("pre_read_rd_en", mem_rd_en, 1);
        cyc();
        rst = 1'b1;
        drive(1, 55, 1);
        chk("rst_pri_wr", mem_wr_en, 0);
        chk("rst_pri_rd", mem_rd_en, 0);
        cyc();
        rst = 1'b0;
        drive(0, 0, 0);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_count", count, 0);
        chk("rr_in_ready", in_ready, 1);
        chk("rr_out_data", out_data, 0);
`ifdef FIFO_CTRL_OVF_EN
        chk("rr_ovf", ovf_err, 0);
`endif
        cyc();
        chk("rr_abandon_valid", out_valid, 0);
        chk("rr_abandon_rd", mem_rd_en, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
